// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops DATA_W-bit entries from a show-ahead FIFO and packs
// PACK_N of them into one wide word with a ready/valid output handshake.
// A partial word is closed early by flush_req. Defining PACK_TIMEOUT_EN adds
// an idle counter that also closes a partial word after TIMEOUT_CYC cycles
// without a pop.
module fifo_word_packer #(
   parameter int DATA_W      = 8,
   parameter int PACK_N      = 4,
   parameter int CNT_W       = 3,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fifo_empty,
   input  logic [DATA_W-1:0]        fifo_rdata,
   output logic                     fifo_rd_en,
   input  logic                     flush_req,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W*PACK_N-1:0] out_data,
   output logic [PACK_N-1:0]        out_byte_en,
   output logic                     pack_busy
);

   if (PACK_N < 2 || PACK_N > 16) begin : g_bad_pack_n
      $error("fifo_word_packer: PACK_N must be 2..16");
   end
   if (CNT_W < $clog2(PACK_N + 1)) begin : g_bad_cnt_w
      $error("fifo_word_packer: CNT_W too narrow for PACK_N");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("fifo_word_packer: TIMEOUT_CYC must be 1..255");
   end

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PACK_N);

   logic [CNT_W-1:0]          cnt;
   logic [DATA_W-1:0]         acc [PACK_N];
   logic                      flush_pend;
   logic                      pop;
   logic                      transfer;
   logic                      flush_set;
   logic [PACK_N-1:0]         fill_mask;
   logic [DATA_W*PACK_N-1:0]  packed_word;

   // Lane k is valid when k < c; used both for masking and for out_byte_en.
   function automatic logic [PACK_N-1:0] lane_mask(input logic [CNT_W-1:0] c);
      logic [PACK_N-1:0] m;
      for (int k = 0; k < PACK_N; k++) begin
         m[k] = (CNT_W'(k) < c);
      end
      return m;
   endfunction

   // Pops stop while the accumulator is full or a flush is draining it, and
   // never happen during reset.
   assign pop        = rst_n && !fifo_empty && (cnt < FULL_CNT) && !flush_pend;
   assign fifo_rd_en = pop;

   // A word moves to the output when full (or flushed with data) and the
   // output register is free or being drained this cycle. A pop and a
   // transfer can never coincide, since either condition blocks pops.
   assign transfer = ((cnt == FULL_CNT) || (flush_pend && (cnt != '0)))
                     && (!out_valid || out_ready);

   assign pack_busy = (cnt != '0) || out_valid || flush_pend;
   assign fill_mask = lane_mask(cnt);

`ifdef PACK_TIMEOUT_EN
   localparam logic [7:0] IDLE_MAX = 8'(TIMEOUT_CYC);

   logic [7:0] idle_cnt;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v >= IDLE_MAX) ? IDLE_MAX : v + 8'd1;
   endfunction

   // Idle counter: counts cycles a partial word waits without a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= '0;
      end else if (pop || (cnt == '0)) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= sat_inc(idle_cnt);
      end
   end

   assign flush_set = (flush_req || (idle_cnt == IDLE_MAX)) && (cnt != '0);
`else
   assign flush_set = flush_req && (cnt != '0);
`endif

   // Flush pending: set by a flush request on a non-empty word, cleared when
   // that word transfers (a transfer wins so no flush is left on cnt=0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_pend <= 1'b0;
      end else if (transfer) begin
         flush_pend <= 1'b0;
      end else if (flush_set) begin
         flush_pend <= 1'b1;
      end
   end

   // Accumulator and lane count: each pop lands in lane cnt.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         for (int k = 0; k < PACK_N; k++) begin
            acc[k] <= '0;
         end
      end else if (transfer) begin
         cnt <= '0;
      end else if (pop) begin
         cnt <= cnt + 1'b1;
         for (int k = 0; k < PACK_N; k++) begin
            if (cnt == CNT_W'(k)) begin
               acc[k] <= fifo_rdata;
            end
         end
      end
   end

   // Packed word with unfilled lanes forced to zero so stale lanes never leak.
   always_comb begin
      packed_word = '0;
      for (int k = 0; k < PACK_N; k++) begin
         if (fill_mask[k]) begin
            packed_word[k*DATA_W +: DATA_W] = acc[k];
         end
      end
   end

   // Output register: loads on transfer, drops valid on a plain handshake,
   // otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_byte_en <= '0;
      end else if (transfer) begin
         out_valid   <= 1'b1;
         out_data    <= packed_word;
         out_byte_en <= fill_mask;
      end else if (out_valid && out_ready) begin
         out_valid   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer (DATA_W=8, PACK_N=4). Compile with
// +define+PACK_TIMEOUT_EN to exercise the idle-flush variant.
module tb_fifo_word_packer;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        fifo_rd_en;
   logic        flush_req;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic [3:0]  out_byte_en;
   logic        pack_busy;

   int n_checks = 0;
   int n_err    = 0;

   fifo_word_packer #(
      .DATA_W(8), .PACK_N(4), .CNT_W(3), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .fifo_rd_en(fifo_rd_en), .flush_req(flush_req), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_byte_en(out_byte_en),
      .pack_busy(pack_busy)
   );

   always #5 clk = ~clk;

   // Upstream FIFO contents, head at index 0.
   logic [7:0] fq [$];

   // Reference model state.
   logic [7:0]  m_lanes [$];
   bit          m_pend;
   bit          m_ov;
   logic [31:0] m_od;
   logic [3:0]  m_be;
   int          m_idle;

   typedef struct {
      int          n;
      logic [31:0] d;
      bit          fl;
      logic [31:0] ed;
      logic [3:0]  eb;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive_fifo();
      fifo_empty = (fq.size() == 0);
      fifo_rdata = (fq.size() == 0) ? 8'($urandom) : fq[0];
   endtask

   task automatic push(input logic [7:0] d);
      fq.push_back(d);
      drive_fifo();
   endtask

   task automatic model_reset();
      m_lanes.delete();
      m_pend = 0; m_ov = 0; m_od = '0; m_be = '0; m_idle = 0;
   endtask

   task automatic model_step();
      int sz;
      bit pop, xfer, fset;
      sz   = m_lanes.size();
      pop  = !fifo_empty && (sz < 4) && !m_pend;
      xfer = ((sz == 4) || (m_pend && sz > 0)) && (!m_ov || out_ready);
      fset = flush_req && (sz > 0);
`ifdef PACK_TIMEOUT_EN
      if (m_idle == TO && sz > 0) fset = 1;
      if (pop || sz == 0) m_idle = 0;
      else if (m_idle < TO) m_idle = m_idle + 1;
`endif
      if (xfer) begin
         m_od = '0;
         for (int i = 0; i < sz; i++) m_od = m_od | (32'(m_lanes[i]) << (8 * i));
         m_be = 4'((1 << sz) - 1);
         m_ov = 1;
         m_lanes.delete();
         m_pend = 0;
      end else begin
         if (m_ov && out_ready) m_ov = 0;
         if (fset) m_pend = 1;
      end
      if (pop) m_lanes.push_back(fifo_rdata);
   endtask

   task automatic check_state();
      chk("rd_en", 32'(fifo_rd_en), 32'(!fifo_empty && m_lanes.size() < 4 && !m_pend));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("pack_busy", 32'(pack_busy), 32'(m_lanes.size() > 0 || m_ov || m_pend));
      if (m_ov) begin
         chk("out_data", out_data, m_od);
         chk("out_byte_en", 32'(out_byte_en), 32'(m_be));
      end
   endtask

   // One clock: check at the falling edge, advance model, update FIFO after the edge.
   task automatic tick();
      logic rd;
      @(negedge clk);
      check_state();
      rd = fifo_rd_en;
      model_step();
      @(posedge clk);
      #1;
      if (rd && fq.size() > 0) void'(fq.pop_front());
      drive_fifo();
   endtask

   initial begin
      bit          got, sent;
      logic [31:0] wd, tmp;
      logic [3:0]  wb;
      int          at;

      vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'b1111};
      vecs[1] = '{2, 32'h00000B0A, 1'b1, 32'h00000B0A, 4'b0011};
      vecs[2] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'b0001};
      vecs[3] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'b0111};
      vecs[4] = '{4, 32'hEFBEADDE, 1'b0, 32'hEFBEADDE, 4'b1111};

      // Reset state, with a non-empty FIFO to show reset blocks pops.
      rst_n = 0; flush_req = 0; out_ready = 1;
      fifo_empty = 0; fifo_rdata = 8'hA5;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_byte_en", 32'(out_byte_en), 0);
      chk("rst_rd_en", 32'(fifo_rd_en), 0);
      chk("rst_busy", 32'(pack_busy), 0);
      drive_fifo();
      rst_n = 1;
      tick();

      // Table of single words, full and flushed.
      for (int v = 0; v < 5; v++) begin
         got = 0; sent = 0; out_ready = 1;
         for (int b = 0; b < vecs[v].n; b++) begin
            tmp = vecs[v].d >> (8 * b);
            push(tmp[7:0]);
         end
         for (int c = 0; c < 30 && !got; c++) begin
            flush_req = vecs[v].fl && !sent && (fq.size() == 0) && (c > 0);
            if (flush_req) sent = 1;
            tick();
            if (out_valid) begin got = 1; wd = out_data; wb = out_byte_en; end
         end
         flush_req = 0;
         chk($sformatf("vec%0d_seen", v), 32'(got), 1);
         chk($sformatf("vec%0d_data", v), wd, vecs[v].ed);
         chk($sformatf("vec%0d_be", v), 32'(wb), 32'(vecs[v].eb));
         tick();
         chk($sformatf("vec%0d_idle", v), 32'(pack_busy), 0);
      end

      // Back-pressure: two words queued behind a stalled output.
      out_ready = 0;
      for (int i = 1; i <= 8; i++) push(8'(i));
      repeat (10) tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_first", out_data, 32'h04030201);
      chk("bp_rd_en_off", 32'(fifo_rd_en), 0);
      chk("bp_fifo_drained", 32'(fq.size()), 0);
      out_ready = 1;
      tick();
      chk("bp_second", out_data, 32'h08070605);
      chk("bp_second_be", 32'(out_byte_en), 32'hF);
      repeat (2) tick();

      // Flush with nothing accumulated is ignored.
      flush_req = 1; tick(); flush_req = 0;
      got = 0;
      for (int c = 0; c < 5; c++) begin tick(); if (out_valid) got = 1; end
      chk("empty_flush_no_word", 32'(got), 0);
      chk("empty_flush_busy", 32'(pack_busy), 0);

      // Flush on the edge the fourth lane lands gives a full word.
      got = 0;
      for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
      for (int c = 0; c < 20 && !got; c++) begin
         flush_req = (fq.size() == 1);
         tick();
         if (out_valid) begin got = 1; wd = out_data; wb = out_byte_en; end
      end
      flush_req = 0;
      chk("edge_flush_seen", 32'(got), 1);
      chk("edge_flush_data", wd, 32'h33323130);
      chk("edge_flush_be", 32'(wb), 32'hF);
      repeat (2) tick();

      // Reset mid-word with a word held at the output.
      out_ready = 0;
      for (int i = 0; i < 7; i++) push(8'hC0 + 8'(i));
      repeat (8) tick();
      chk("pre_rst_valid", 32'(out_valid), 1);
      rst_n = 0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 0);
      chk("async_rst_data", out_data, 0);
      chk("async_rst_be", 32'(out_byte_en), 0);
      chk("async_rst_busy", 32'(pack_busy), 0);
      fq.delete(); drive_fifo(); model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1; out_ready = 1;
      got = 0;
      for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
      for (int c = 0; c < 20 && !got; c++) begin
         tick();
         if (out_valid) begin got = 1; wd = out_data; wb = out_byte_en; end
      end
      chk("post_rst_seen", 32'(got), 1);
      chk("post_rst_data", wd, 32'h74737271);
      chk("post_rst_be", 32'(wb), 32'hF);
      repeat (2) tick();

      // Single lane left waiting on an empty FIFO.
      got = 0; at = 0;
      push(8'h5A);
      for (int c = 1; c <= 40 && !got; c++) begin
         tick();
         if (out_valid) begin got = 1; wd = out_data; wb = out_byte_en; at = c; end
      end
`ifdef PACK_TIMEOUT_EN
      chk("timeout_seen", 32'(got), 1);
      chk("timeout_cycle", 32'(at), 19);
      chk("timeout_data", wd, 32'h0000005A);
      chk("timeout_be", 32'(wb), 32'h1);
`else
      chk("no_timeout_word", 32'(got), 0);
      chk("no_timeout_busy", 32'(pack_busy), 1);
      flush_req = 1; tick(); flush_req = 0;
      tick();
      chk("manual_flush_valid", 32'(out_valid), 1);
      chk("manual_flush_data", out_data, 32'h0000005A);
      chk("manual_flush_be", 32'(out_byte_en), 32'h1);
`endif
      repeat (2) tick();

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0 && fq.size() < 6) push(8'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         flush_req = ($urandom_range(0, 9) == 0);
         tick();
      end
      flush_req = 0; out_ready = 1;
      for (int c = 0; c < 60; c++) begin
         flush_req = (c % 8 == 0);
         tick();
      end
      flush_req = 0;
      tick();
      chk("drain_busy", 32'(pack_busy), 0);
      chk("drain_fifo", 32'(fq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter DATA_W, default 8: width of one FIFO entry (one lane) in bits.
REQ-002 Parameter PACK_N, default 4: lanes per output word, range 2..16.
REQ-003 Parameter CNT_W, default 3: lane-counter width, at least clog2(PACK_N+1).
REQ-004 Parameter TIMEOUT_CYC, default 16: idle-flush threshold in cycles, range 1..255; used only with PACK_TIMEOUT_EN.
REQ-005 Port clk  in  1: single clock, rising edge.
REQ-006 Port rst_n  in  1: reset, asynchronous and active-low.
REQ-007 Port fifo_empty  in  1: upstream FIFO has no entries.
REQ-008 Port fifo_rdata  in  DATA_W: upstream FIFO head entry (show-ahead), valid whenever fifo_empty=0.
REQ-009 Port fifo_rd_en  out  1: pops the FIFO head at the rising edge on which it is high.
REQ-010 Port flush_req  in  1: single-cycle request to close the current partial word.
REQ-011 Port out_valid  out  1: out_data/out_byte_en hold a packed word.
REQ-012 Port out_ready  in  1: downstream accepts the word when out_valid=1 and out_ready=1.
REQ-013 Port out_data  out  DATA_W*PACK_N: packed word; lane k is out_data[k*DATA_W +: DATA_W].
REQ-014 Port out_byte_en  out  PACK_N: bit k set means lane k holds valid data.
REQ-015 Port pack_busy  out  1: high if lane count is nonzero, out_valid=1 or a flush is pending.

Function
REQ-016 The block SHALL hold an accumulator of PACK_N lanes and a lane count cnt (0..PACK_N).
REQ-017 fifo_rd_en SHALL equal (fifo_empty=0) AND (cnt<PACK_N) AND (no flush pending), combinationally.
REQ-018 On each pop, fifo_rdata SHALL be written to lane cnt and cnt SHALL increment; the first popped entry goes to lane 0.
REQ-019 A transfer SHALL occur at a rising edge when (cnt==PACK_N, or flush pending with cnt>0) AND (out_valid=0 or out_ready=1).
REQ-020 On a transfer: out_data takes the accumulator, with unfilled lanes forced to zero; out_byte_en takes the lowest cnt bits set; out_valid is set to 1; cnt is set to 0; any pending flush clears.
REQ-021 When out_valid=1 and out_ready=1 with no transfer on that edge, out_valid SHALL go to 0.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_byte_en and out_valid SHALL hold stable.
REQ-023 Latency: if the PACK_N-th lane is captured at edge e and the output is free, out_valid SHALL rise at edge e+1; peak throughput is one word per PACK_N+1 cycles.
REQ-024 If flush_req=1 with cnt>0, a flush SHALL become pending; pops stop and the partial word transfers per REQ-019.
REQ-025 If flush_req=1 with cnt==0, the request SHALL be ignored and no empty word emitted.
REQ-026 If flush_req=1 while a flush is already pending, it SHALL have no additional effect.
REQ-027 If flush_req=1 on the edge where cnt reaches PACK_N, the result SHALL be a normal full word with out_byte_en all ones.
REQ-028 fifo_empty=1 SHALL never cause a pop; fifo_rdata is ignored while empty.

Reset
REQ-029 While rst_n=0: cnt=0, accumulator=0, out_valid=0, out_data=0, out_byte_en=0, flush pending=0, idle counter=0, fifo_rd_en=0, pack_busy=0.
REQ-030 Reset mid-word or mid-handshake SHALL discard all partial and pending data without emitting it.

Configuration
REQ-031 Macro PACK_TIMEOUT_EN, when defined, SHALL add an idle counter: it clears on any pop or when cnt==0, otherwise increments, saturating at TIMEOUT_CYC.
REQ-032 With PACK_TIMEOUT_EN defined, the idle counter reaching TIMEOUT_CYC with cnt>0 SHALL set flush pending exactly as flush_req does.
REQ-033 Without PACK_TIMEOUT_EN, no idle counter SHALL exist and partial words SHALL leave only via flush_req.

Verification
REQ-034 PACK_N=4, FIFO holds 0x11,0x22,0x33,0x44, out_ready=1 -> one word out_data=0x44332211, out_byte_en=4'b1111, out_valid high one cycle.
REQ-035 0x0A,0x0B popped, then flush_req -> out_data=0x00000B0A, out_byte_en=4'b0011, cnt=0, then pack_busy=0.
REQ-036 8 entries 0x01..0x08, out_ready=0 for 10 cycles -> first word 0x04030201 holds stable; after 4 more pops fifo_rd_en=0; raise ready -> 0x08070605 follows.
REQ-037 flush_req with cnt=0, and flush_req on the edge cnt reaches 4 -> respectively no word, and one full word with out_byte_en=4'b1111.
REQ-038 rst_n low after 3 pops with out_valid=1 -> all outputs 0 immediately; after release the next 4 pops form a fresh full word.
REQ-039 PACK_TIMEOUT_EN, TIMEOUT_CYC=16, one pop 0x5A then FIFO empty -> partial word 0x0000005A, out_byte_en=4'b0001 after the idle count reaches 16; without the macro, no word emitted.
